// File: rtl/load_store_unit_if.sv
// Data-bus interface for the load/store unit: request/grant/read-valid handshake.
// The master drives the request fields; the slave (memory) returns grant and read data.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-bus access per load/store, aligns store data into
// byte lanes, extracts and extends load data, and stalls the core until the access ends.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses instead of
// masking the low address bits).
module load_store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] data_memory_output,
    output logic              load_valid,
    output logic              misaligned,
    load_store_unit_if.master dbus
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e            state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [1:0]        off_q;
    logic              size_h_q;
    logic              size_w_q;
    logic              sign_q;
    logic [DATA_W-1:0] dmo_q;
    logic              load_valid_q;
    logic              misaligned_q;

    logic              access;
    logic              size_h;
    logic              size_w;
    logic [1:0]        off;
    logic              trap;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;

    assign access = mem_read_en | mem_write_en;
    // funct3[1:0] = 11 falls into the word case along with 10
    assign size_h = (funct3[1:0] == 2'b01);
    assign size_w = funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
    assign off  = addr[1:0];
    assign trap = (size_h & addr[0]) | (size_w & (addr[1:0] != 2'b00));
`else
    // Mask low address bits to the access size so the access is always aligned
    assign off  = {addr[1] & ~size_w, addr[0] & ~size_h & ~size_w};
    assign trap = 1'b0;
`endif

    // Store lane placement: replicate the datum and enable only the addressed lanes
    always_comb begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{store_data[7:0]}};
        if (size_w) begin
            be_d    = 4'b1111;
            wdata_d = store_data;
        end else if (size_h) begin
            be_d    = 4'b0011 << off;
            wdata_d = {2{store_data[15:0]}};
        end
    end

    assign shifted = dbus.rdata >> {off_q, 3'b000};

    // Load extraction: pick the addressed byte/half and sign- or zero-extend it
    always_comb begin
        load_ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
        if (size_w_q) begin
            load_ext = shifted;
        end else if (size_h_q) begin
            load_ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
        end
    end

    // Access FSM with registered bus request fields and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            off_q        <= 2'b00;
            size_h_q     <= 1'b0;
            size_w_q     <= 1'b0;
            sign_q       <= 1'b0;
            dmo_q        <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        // Store wins when both enables are high
                        we_q     <= mem_write_en;
                        addr_q   <= {addr[ADDR_W-1:2], 2'b00};
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                        off_q    <= off;
                        size_h_q <= size_h;
                        size_w_q <= size_w;
                        sign_q   <= ~funct3[2];
                        if (trap) begin
                            state_q      <= StDone;
                            misaligned_q <= 1'b1;
                            if (!mem_write_en) begin
                                dmo_q        <= '0;
                                load_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (dbus.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? StDone : StWaitR;
                    end
                end
                StWaitR: begin
                    if (dbus.rvalid) begin
                        dmo_q        <= load_ext;
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall covers the request-recognition cycle and every bus cycle, but not DONE
    assign stall = ((state_q == StIdle) & access) | (state_q == StReq) | (state_q == StWaitR);

    assign data_memory_output = dmo_q;
    assign load_valid         = load_valid_q;
    assign misaligned         = misaligned_q;

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.wdata = wdata_q;
    assign dbus.be    = be_q;

endmodule
